// File: rtl/cla_nibble_seq.sv
// rtl/cla_nibble_seq.sv - multi-cycle add/sub sequencer reusing one 4-bit carry-lookahead nibble stage
module cla_nibble_seq #(
  parameter int WIDTH = 16,
  parameter int NNIB  = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int IW = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NNIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;
  logic [3:0] s;

  // Nibble stage: every carry is formed directly from g/p and the carry register
  always_comb begin
    nib_a = opa[4*idx +: 4];
    nib_b = opb[4*idx +: 4];
    p     = nib_a ^ nib_b;
    g     = nib_a & nib_b;
    c[0]  = carry;
    c[1]  = g[0] | (p[0] & carry);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & carry);
    s     = p ^ c[3:0];
  end

  // Sequencer: accept operands, walk nibbles LSB first, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in
            opa      <= a;
            opb      <= op_sub ? ~b : b;
            carry    <= op_sub;
            idx      <= '0;
            sum      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= s;
          carry           <= c[4];
          if (idx == LAST) begin
            sum[WIDTH] <= c[4];
            state      <= DONE;
            out_valid  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // The handshake edge only consumes; a new request waits for the IDLE cycle
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
